uart_reg_ctrl: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 25 ++
 rtl/uart_tx_seq.sv | 60 ++++++
 rtl/uart_reg_ctrl.sv | 153 +++++++++++++++
 tb/tb_uart_reg_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared command encoding, state names and default response bytes for the
// UART register controller and its transmit sequencer.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GET_DATA = 3'd1,
      ST_COMMIT   = 3'd2,
      ST_TX_LOAD  = 3'd3,
      ST_TX_PULSE = 3'd4,
      ST_TX_GUARD = 3'd5,
      ST_TX_WAIT  = 3'd6
   } state_e;

   localparam logic [7:0] CMD_WR        = 8'h80;
   localparam logic [7:0] CMD_RD        = 8'h00;
   localparam logic [7:0] CMD_ADDR_MASK = 8'h03;
   localparam logic [7:0] ACK_DEFAULT   = 8'hA5;
   localparam logic [7:0] NAK_DEFAULT   = 8'hEE;

   function automatic logic cmd_is(input logic [7:0] b, input logic [7:0] op);
      return (b & ~CMD_ADDR_MASK) == op;
   endfunction

endpackage

// File: rtl/uart_tx_seq.sv
// Response sequencer: feeds up to four queued bytes, MSB first, into the
// UART transmitter using its send/busy handshake.
module uart_tx_seq
   import uart_cmd_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic [2:0]  i_len,
   input  logic [31:0] i_data,
   input  logic        i_tx_busy,
   output logic [7:0]  o_sbyte,
   output logic        o_send,
   output logic        o_done
);

   state_e      r_state;
   logic [31:0] r_queue;
   logic [2:0]  r_remain;
   logic [7:0]  r_sbyte;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_queue  <= 32'h0;
         r_remain <= 3'd0;
         r_sbyte  <= 8'h0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_queue  <= i_data;
                  r_remain <= i_len;
                  r_state  <= ST_TX_LOAD;
               end
            end
            ST_TX_LOAD: begin
               r_sbyte  <= r_queue[31:24];
               r_queue  <= {r_queue[23:0], 8'h0};
               r_remain <= r_remain - 3'd1;
               r_state  <= ST_TX_PULSE;
            end
            ST_TX_PULSE: r_state <= ST_TX_GUARD;
            // busy has not risen yet in the guard cycle, so it is not looked at
            ST_TX_GUARD: r_state <= ST_TX_WAIT;
            ST_TX_WAIT: begin
               if (!i_tx_busy) begin
                  r_state <= (r_remain != 3'd0) ? ST_TX_LOAD : ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_sbyte = r_sbyte;
   assign o_send  = (r_state == ST_TX_PULSE);
   assign o_done  = (r_state == ST_TX_WAIT) && !i_tx_busy && (r_remain == 3'd0);

endmodule

// File: rtl/uart_reg_ctrl.sv
// Command parser between the UART core and the four 32-bit NCO configuration
// registers; responses are handed to uart_tx_seq.
module uart_reg_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CLKS = 1000000,
   parameter logic [7:0]  ACK_BYTE     = ACK_DEFAULT,
   parameter logic [7:0]  NAK_BYTE     = NAK_DEFAULT,
   parameter logic [31:0] REG0_INIT    = 32'h0,
   parameter logic [31:0] REG1_INIT    = 32'h0,
   parameter logic [31:0] REG2_INIT    = 32'h0,
   parameter logic [31:0] REG3_INIT    = 32'h0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [7:0]   rx_byte,
   input  logic         rbyte_ready,
   input  logic         tx_busy,
   output logic [7:0]   sbyte,
   output logic         send,
   output logic [127:0] regs,
   output logic [3:0]   wr_strobe,
   output logic         frame_err
);

   localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CLKS - 1);

   state_e      r_state;
   logic [1:0]  r_addr;
   logic [31:0] r_buf;
   logic [1:0]  r_nbytes;
   logic [19:0] r_tcnt;
   logic        r_frame_err;
   logic [31:0] r_regs [4];

   logic        w_is_wr;
   logic        w_is_rd;
   logic [1:0]  w_rx_addr;
   logic        w_start;
   logic [2:0]  w_len;
   logic [31:0] w_data;
   logic        w_done;
   logic [3:0]  w_wr_strobe;

   assign w_is_wr   = cmd_is(rx_byte, CMD_WR);
   assign w_is_rd   = cmd_is(rx_byte, CMD_RD);
   assign w_rx_addr = rx_byte[1:0];

   // Responses start in the same cycle the parser decides, so the sequencer
   // is already busy before another byte could be taken.
   always_comb begin
      w_start     = 1'b0;
      w_len       = 3'd0;
      w_data      = 32'h0;
      w_wr_strobe = 4'b0000;
      if (r_state == ST_IDLE && rbyte_ready) begin
         if (w_is_rd) begin
            w_start = 1'b1;
            w_len   = 3'd4;
            w_data  = r_regs[w_rx_addr];
         end else if (!w_is_wr) begin
            w_start = 1'b1;
            w_len   = 3'd1;
            w_data  = {NAK_BYTE, 24'h0};
         end
      end
      if (r_state == ST_COMMIT) begin
         w_start             = 1'b1;
         w_len               = 3'd2;
         w_data              = {ACK_BYTE, 6'b0, r_addr, 16'h0};
         w_wr_strobe[r_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_addr      <= 2'd0;
         r_buf       <= 32'h0;
         r_nbytes    <= 2'd0;
         r_tcnt      <= 20'd0;
         r_frame_err <= 1'b0;
         r_regs[0]   <= REG0_INIT;
         r_regs[1]   <= REG1_INIT;
         r_regs[2]   <= REG2_INIT;
         r_regs[3]   <= REG3_INIT;
      end else begin
         r_frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rbyte_ready) begin
                  if (w_is_wr) begin
                     r_addr   <= w_rx_addr;
                     r_nbytes <= 2'd0;
                     r_buf    <= 32'h0;
                     r_tcnt   <= 20'd0;
                     r_state  <= ST_GET_DATA;
                  end else if (w_is_rd) begin
                     r_state  <= ST_TX_WAIT;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= ST_TX_WAIT;
                  end
               end
            end
            ST_GET_DATA: begin
               if (rbyte_ready) begin
                  r_buf    <= {r_buf[23:0], rx_byte};
                  r_tcnt   <= 20'd0;
                  r_nbytes <= r_nbytes + 2'd1;
                  if (r_nbytes == 2'd3) begin
                     r_state <= ST_COMMIT;
                  end
               end else if (r_tcnt >= TIMEOUT_LAST) begin
                  r_frame_err <= 1'b1;
                  r_buf       <= 32'h0;
                  r_state     <= ST_IDLE;
               end else if (r_tcnt != '1) begin
                  r_tcnt <= r_tcnt + 20'd1;
               end
            end
            ST_COMMIT: begin
               r_regs[r_addr] <= r_buf;
               r_state        <= ST_TX_WAIT;
            end
            // Whole response owned by the sequencer; received bytes are dropped.
            ST_TX_WAIT: begin
               if (w_done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   uart_tx_seq u_tx_seq (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_start),
      .i_len     (w_len),
      .i_data    (w_data),
      .i_tx_busy (tx_busy),
      .o_sbyte   (sbyte),
      .o_send    (send),
      .o_done    (w_done)
   );

   assign regs      = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
   assign wr_strobe = w_wr_strobe;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Self-checking bench for uart_reg_ctrl: table vectors, hand-written corner
// sequences and randomized commands against a register/response model.
module tb_uart_reg_ctrl;

   localparam int          TO  = 100;
   localparam logic [31:0] I0  = 32'h0000_0000;
   localparam logic [31:0] I1  = 32'h0BAD_F00D;
   localparam logic [31:0] I2  = 32'h0000_0000;
   localparam logic [31:0] I3  = 32'h5A5A_C3C3;
   localparam logic [7:0]  ACK = 8'hA5;
   localparam logic [7:0]  NAK = 8'hEE;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [7:0]   rx_byte = 8'h0;
   logic         rbyte_ready = 1'b0;
   logic         tx_busy = 1'b0;
   logic [7:0]   sbyte;
   logic         send;
   logic [127:0] regs;
   logic [3:0]   wr_strobe;
   logic         frame_err;

   uart_reg_ctrl #(
      .TIMEOUT_CLKS (TO),
      .ACK_BYTE     (ACK),
      .NAK_BYTE     (NAK),
      .REG0_INIT    (I0),
      .REG1_INIT    (I1),
      .REG2_INIT    (I2),
      .REG3_INIT    (I3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_byte     (rx_byte),
      .rbyte_ready (rbyte_ready),
      .tx_busy     (tx_busy),
      .sbyte       (sbyte),
      .send        (send),
      .regs        (regs),
      .wr_strobe   (wr_strobe),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errs = 0;
   int          wr_total = 0;
   int          fe_cnt = 0;
   int          viol = 0;
   int          busy_left = 0;
   bit          rise_pending = 1'b0;
   logic [7:0]  last_sb = 8'h0;
   logic [7:0]  cap_q [$];
   logic [31:0] model [4];

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] data;
      logic [31:0] eb;
      int          elen;
      logic [3:0]  estb;
      logic        efe;
   } vec_t;
   vec_t tbl [10];

   // Transmitter model: busy rises the cycle after send and lasts a random frame.
   always @(negedge clk) begin
      if (reset) begin
         tx_busy      = 1'b0;
         rise_pending = 1'b0;
      end else begin
         if (send) begin
            if (tx_busy || rise_pending) viol++;
            cap_q.push_back(sbyte);
         end else if (tx_busy && sbyte != last_sb) begin
            viol++;
         end
         if (rise_pending) begin
            tx_busy      = 1'b1;
            rise_pending = 1'b0;
         end else if (tx_busy) begin
            if (busy_left <= 1) tx_busy = 1'b0;
            else busy_left--;
         end
         if (send) begin
            rise_pending = 1'b1;
            busy_left    = $urandom_range(3, 10);
            last_sb      = sbyte;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         wr_total += $countones(wr_strobe);
         fe_cnt   += int'(frame_err);
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_regs(input string nm);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s/reg%0d", nm, i), regs[32*i +: 32], model[i]);
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(negedge clk);
      rx_byte     = b;
      rbyte_ready = 1'b1;
      @(negedge clk);
      rbyte_ready = 1'b0;
      rx_byte     = 8'($urandom);
   endtask

   task automatic wait_tx_idle();
      int t = 0;
      while ((tx_busy || rise_pending) && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_sends(input int target);
      int t = 0;
      while (cap_q.size() < target && t < 3000) begin
         @(negedge clk);
         t++;
      end
   endtask

   function automatic void model_resp(input logic [7:0] cmd, output logic [31:0] eb,
                                      output int elen, output logic [3:0] estb,
                                      output logic efe);
      logic [1:0] a;
      a = cmd[1:0];
      eb = 32'h0; elen = 1; estb = 4'b0000; efe = 1'b0;
      if (cmd[7:2] == 6'b100000) begin
         eb = {ACK, 6'b0, a, 16'h0}; elen = 2; estb[a] = 1'b1;
      end else if (cmd[7:2] == 6'b000000) begin
         eb = model[a]; elen = 4;
      end else begin
         eb = {NAK, 24'h0}; efe = 1'b1;
      end
   endfunction

   task automatic run_cmd(input string nm, input logic [7:0] cmd, input logic [31:0] data,
                          input logic [31:0] eb, input int elen, input logic [3:0] estb,
                          input logic efe);
      int base, wr0, fe0, v0;
      logic [3:0] stb;
      logic fe;
      logic [7:0] got;
      base = cap_q.size(); wr0 = wr_total; fe0 = fe_cnt; v0 = viol;
      send_rx(cmd);
      if (cmd[7:2] == 6'b100000) begin
         for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_rx(data[31-8*k -: 8]);
         end
         model[cmd[1:0]] = data;
      end
      stb = wr_strobe;
      fe  = frame_err;
      check({nm, "/strobe"}, 32'(stb), 32'(estb));
      check({nm, "/frame_err"}, 32'(fe), 32'(efe));
      wait_sends(base + elen);
      wait_tx_idle();
      check({nm, "/resp_len"}, cap_q.size() - base, elen);
      for (int k = 0; k < elen; k++) begin
         got = (base + k < cap_q.size()) ? cap_q[base + k] : 8'hxx;
         check($sformatf("%s/byte%0d", nm, k), 32'(got), 32'(eb[31-8*k -: 8]));
      end
      check({nm, "/wr_pulses"}, wr_total - wr0, $countones(estb));
      check({nm, "/fe_pulses"}, fe_cnt - fe0, 32'(efe));
      check({nm, "/handshake"}, viol - v0, 0);
      check_regs(nm);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] eb;
      int          elen, base, wr0, fe0, n;
      logic [3:0]  estb;
      logic        efe, found;
      logic [7:0]  cmd;

      tbl[0] = '{8'h80, 32'h1234_5678, 32'hA500_0000, 2, 4'b0001, 1'b0};
      tbl[1] = '{8'h00, 32'h0,         32'h1234_5678, 4, 4'b0000, 1'b0};
      tbl[2] = '{8'h47, 32'h0,         32'hEE00_0000, 1, 4'b0000, 1'b1};
      tbl[3] = '{8'h83, 32'hDEAD_BEEF, 32'hA503_0000, 2, 4'b1000, 1'b0};
      tbl[4] = '{8'h03, 32'h0,         32'hDEAD_BEEF, 4, 4'b0000, 1'b0};
      tbl[5] = '{8'h01, 32'h0,         32'h0BAD_F00D, 4, 4'b0000, 1'b0};
      tbl[6] = '{8'h84, 32'h0,         32'hEE00_0000, 1, 4'b0000, 1'b1};
      tbl[7] = '{8'hFF, 32'h0,         32'hEE00_0000, 1, 4'b0000, 1'b1};
      tbl[8] = '{8'h82, 32'h0000_00FF, 32'hA502_0000, 2, 4'b0100, 1'b0};
      tbl[9] = '{8'h02, 32'h0,         32'h0000_00FF, 4, 4'b0000, 1'b0};
      model[0] = I0; model[1] = I1; model[2] = I2; model[3] = I3;

      repeat (3) @(negedge clk);
      check("reset/send", 32'(send), 32'h0);
      check("reset/sbyte", 32'(sbyte), 32'h0);
      check("reset/wr_strobe", 32'(wr_strobe), 32'h0);
      check("reset/frame_err", 32'(frame_err), 32'h0);
      check_regs("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_cmd($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].data, tbl[i].eb,
                 tbl[i].elen, tbl[i].estb, tbl[i].efe);
      end

      // Frame abandoned after a silent gap; register 3 keeps its value.
      base = cap_q.size(); wr0 = wr_total; fe0 = fe_cnt;
      send_rx(8'h83);
      send_rx(8'hAA);
      n = 0; found = 1'b0;
      while (!found && n < 300) begin
         @(negedge clk);
         n++;
         if (frame_err) found = 1'b1;
      end
      check("timeout/cycle", n, TO);
      @(negedge clk);
      check("timeout/pulse_width", 32'(frame_err), 32'h0);
      check("timeout/no_tx", cap_q.size() - base, 0);
      check("timeout/no_write", wr_total - wr0, 0);
      check("timeout/fe_pulses", fe_cnt - fe0, 1);
      check_regs("timeout");
      model_resp(8'h03, eb, elen, estb, efe);
      run_cmd("after_timeout", 8'h03, 32'h0, eb, elen, estb, efe);

      // Write command byte arriving mid-response must be ignored.
      model_resp(8'h00, eb, elen, estb, efe);
      base = cap_q.size(); wr0 = wr_total; fe0 = fe_cnt;
      send_rx(8'h00);
      wait_sends(base + 1);
      n = 0;
      while (!tx_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      send_rx(8'h81);
      wait_sends(base + 4);
      wait_tx_idle();
      check("inject/resp_len", cap_q.size() - base, 4);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("inject/byte%0d", k),
               32'((base + k < cap_q.size()) ? cap_q[base + k] : 8'hxx),
               32'(eb[31-8*k -: 8]));
      end
      check("inject/no_write", wr_total - wr0, 0);
      check("inject/no_fe", fe_cnt - fe0, 0);
      model_resp(8'h01, eb, elen, estb, efe);
      run_cmd("inject/followup", 8'h01, 32'h0, eb, elen, estb, efe);

      // Reset in the middle of a four-byte read response.
      base = cap_q.size();
      send_rx(8'h00);
      wait_sends(base + 2);
      check("rst_mid/pre_sends", cap_q.size() - base, 2);
      @(negedge clk); #1 reset = 1'b1;
      @(negedge clk); #1 reset = 1'b0;
      check("rst_mid/send", 32'(send), 32'h0);
      check("rst_mid/sbyte", 32'(sbyte), 32'h0);
      check("rst_mid/wr_strobe", 32'(wr_strobe), 32'h0);
      check("rst_mid/frame_err", 32'(frame_err), 32'h0);
      model[0] = I0; model[1] = I1; model[2] = I2; model[3] = I3;
      check_regs("rst_mid");
      repeat (80) @(negedge clk);
      check("rst_mid/no_more_sends", cap_q.size() - base, 2);
      model_resp(8'h03, eb, elen, estb, efe);
      run_cmd("rst_mid/read3", 8'h03, 32'h0, eb, elen, estb, efe);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 2))
            0: cmd = 8'h80 | 8'($urandom_range(0, 3));
            1: cmd = 8'($urandom_range(0, 3));
            default: begin
               cmd = 8'($urandom);
               if (cmd[6:2] == 5'b0) cmd[4] = 1'b1;
            end
         endcase
         model_resp(cmd, eb, elen, estb, efe);
         run_cmd($sformatf("rand%0d", i), cmd, $urandom, eb, elen, estb, efe);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
